// File: rtl/counter_ctrl_pkg.sv
// Shared encodings for the counter sequencer: FSM state values and mode bits.
package counter_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_HOLD = 2'b10,
    ST_DONE = 2'b11
  } state_t;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/sync_counter.sv
// SIZE-bit synchronous up-counter; clear beats enable, async reset clears.
module sync_counter #(
  parameter int SIZE = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            en,
  output logic [SIZE-1:0] Q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Q <= '0;
    end else if (clr) begin
      Q <= '0;
    end else if (en) begin
      Q <= Q + SIZE'(1);
    end
  end

endmodule

// File: rtl/counter_ctrl.sv
// Sequencer for a SIZE-bit up-counter: start/stop/pause, one-shot or periodic
// terminal count, one-cycle done pulse and a wrapping completed-period count.
module counter_ctrl
  import counter_ctrl_pkg::*;
#(
  parameter int SIZE   = 4,
  parameter int PCNT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              pause,
  input  logic              mode,
  input  logic [SIZE-1:0]   term_cnt,
  output logic [SIZE-1:0]   Q,
  output logic [1:0]        state,
  output logic              busy,
  output logic              done,
  output logic [PCNT_W-1:0] periods
);

  state_t              cur_st, nxt_st;
  logic [SIZE-1:0]     term_r, term_nxt;
  logic                mode_r, mode_nxt;
  logic                done_nxt;
  logic [PCNT_W-1:0]   periods_nxt;
  logic                cnt_clr, cnt_en;
  logic                at_term;

  sync_counter #(.SIZE(SIZE)) u_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .en  (cnt_en),
    .Q   (Q)
  );

  assign at_term = (Q == term_r);
  assign state   = cur_st;
  assign busy    = (cur_st == ST_RUN) || (cur_st == ST_HOLD);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_st  <= ST_IDLE;
      term_r  <= '0;
      mode_r  <= MODE_ONESHOT;
      done    <= 1'b0;
      periods <= '0;
    end else begin
      cur_st  <= nxt_st;
      term_r  <= term_nxt;
      mode_r  <= mode_nxt;
      done    <= done_nxt;
      periods <= periods_nxt;
    end
  end

  // Command priority is stop > start > pause; start is only honoured outside RUN/HOLD.
  always_comb begin
    nxt_st      = cur_st;
    term_nxt    = term_r;
    mode_nxt    = mode_r;
    done_nxt    = 1'b0;
    periods_nxt = periods;
    cnt_clr     = 1'b0;
    cnt_en      = 1'b0;
    case (cur_st)
      ST_IDLE, ST_DONE: begin
        if (stop) begin
          nxt_st  = ST_IDLE;
          cnt_clr = 1'b1;
        end else if (start) begin
          term_nxt    = term_cnt;
          mode_nxt    = mode;
          cnt_clr     = 1'b1;
          periods_nxt = '0;
          // A zero one-shot completes on the start edge itself.
          if ((term_cnt == '0) && (mode == MODE_ONESHOT)) begin
            nxt_st      = ST_DONE;
            done_nxt    = 1'b1;
            periods_nxt = PCNT_W'(1);
          end else begin
            nxt_st = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (stop) begin
          nxt_st  = ST_IDLE;
          cnt_clr = 1'b1;
        end else if (pause) begin
          nxt_st = ST_HOLD;
        end else if (!at_term) begin
          cnt_en = 1'b1;
        end else begin
          done_nxt    = 1'b1;
          periods_nxt = periods + PCNT_W'(1);
          if (mode_r == MODE_PERIODIC) begin
            cnt_clr = 1'b1;
          end else begin
            nxt_st = ST_DONE;
          end
        end
      end
      ST_HOLD: begin
        if (stop) begin
          nxt_st  = ST_IDLE;
          cnt_clr = 1'b1;
        end else if (!pause) begin
          nxt_st = ST_RUN;
        end
      end
      default: begin
        nxt_st = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_counter_ctrl.sv
// Scoreboarded bench for counter_ctrl: a behavioural model predicts every cycle,
// plus fixed anchor values for the key sequences.
module tb_counter_ctrl;
  import counter_ctrl_pkg::*;

  localparam int SIZE   = 4;
  localparam int PCNT_W = 8;

  logic              clk, rst, start, stop, pause, mode;
  logic [SIZE-1:0]   term_cnt, Q;
  logic [1:0]        state;
  logic              busy, done;
  logic [PCNT_W-1:0] periods;

  typedef struct packed {
    logic [SIZE-1:0]   q;
    logic [1:0]        st;
    logic              busy;
    logic              done;
    logic [PCNT_W-1:0] per;
  } exp_t;

  exp_t sbq[$];
  int   checkCount = 0;
  int   passCount  = 0;
  int   cycle      = 0;

  logic [SIZE-1:0]   mQ, mTerm;
  logic [1:0]        mSt;
  logic              mMode, mDone;
  logic [PCNT_W-1:0] mPer;

  counter_ctrl #(.SIZE(SIZE), .PCNT_W(PCNT_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .stop     (stop),
    .pause    (pause),
    .mode     (mode),
    .term_cnt (term_cnt),
    .Q        (Q),
    .state    (state),
    .busy     (busy),
    .done     (done),
    .periods  (periods)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs !== exp) begin
      $display("[TB] FAIL %s (cycle %0d): got %0h, expected %0h", tag, cycle, obs, exp);
    end else begin
      passCount++;
    end
  endtask

  task automatic modelReset();
    mQ = '0; mTerm = '0; mSt = ST_IDLE; mMode = 1'b0; mDone = 1'b0; mPer = '0;
  endtask

  // Reference behaviour for one clock edge.
  task automatic modelStep(input logic s, input logic sp, input logic pa, input logic md,
                           input logic [SIZE-1:0] tc);
    mDone = 1'b0;
    if (sp) begin
      mSt = ST_IDLE;
      mQ  = '0;
    end else if (mSt == ST_RUN) begin
      if (pa) begin
        mSt = ST_HOLD;
      end else if (mQ != mTerm) begin
        mQ = mQ + 1'b1;
      end else begin
        mDone = 1'b1;
        mPer  = mPer + 1'b1;
        if (mMode) mQ = '0;
        else mSt = ST_DONE;
      end
    end else if (mSt == ST_HOLD) begin
      if (!pa) mSt = ST_RUN;
    end else if (s) begin
      mTerm = tc;
      mMode = md;
      mQ    = '0;
      mPer  = '0;
      if (tc == '0 && !md) begin
        mSt   = ST_DONE;
        mDone = 1'b1;
        mPer  = 1;
      end else begin
        mSt = ST_RUN;
      end
    end
  endtask

  task automatic applyStimulus(input logic s, input logic sp, input logic pa, input logic md,
                               input logic [SIZE-1:0] tc);
    exp_t e;
    start = s; stop = sp; pause = pa; mode = md; term_cnt = tc;
    modelStep(s, sp, pa, md, tc);
    e.q    = mQ;
    e.st   = mSt;
    e.busy = (mSt == ST_RUN) || (mSt == ST_HOLD);
    e.done = mDone;
    e.per  = mPer;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    cycle++;
    e = sbq.pop_front();
    checkOutput("q", 32'(Q), 32'(e.q));
    checkOutput("state", 32'(state), 32'(e.st));
    checkOutput("busy", 32'(busy), 32'(e.busy));
    checkOutput("done", 32'(done), 32'(e.done));
    checkOutput("periods", 32'(periods), 32'(e.per));
  endtask

  task automatic runCycles(input int n, input logic pa, input logic md, input logic [SIZE-1:0] tc);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, pa, md, tc);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0; mode = 1'b0; term_cnt = '0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_q", 32'(Q), 32'd0);
    checkOutput("rst_state", 32'(state), 32'(ST_IDLE));
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_periods", 32'(periods), 32'd0);
    rst = 1'b0;

    // One-shot term=5; term/mode inputs change after start and must be ignored.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'd5);
    checkOutput("os_q0", 32'(Q), 32'd0);
    runCycles(5, 1'b0, 1'b1, 4'd9);
    checkOutput("os_q5", 32'(Q), 32'd5);
    checkOutput("os_run", 32'(state), 32'(ST_RUN));
    runCycles(1, 1'b0, 1'b1, 4'd9);
    checkOutput("os_done_st", 32'(state), 32'(ST_DONE));
    checkOutput("os_done", 32'(done), 32'd1);
    checkOutput("os_periods", 32'(periods), 32'd1);
    runCycles(1, 1'b0, 1'b0, 4'd0);
    checkOutput("os_done_clr", 32'(done), 32'd0);
    checkOutput("os_q_hold", 32'(Q), 32'd5);

    // Periodic term=3 for 12 cycles.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 4'd3);
    runCycles(12, 1'b0, 1'b0, 4'd0);
    checkOutput("per_periods", 32'(periods), 32'd3);
    checkOutput("per_wrap_q", 32'(Q), 32'd0);
    checkOutput("per_wrap_done", 32'(done), 32'd1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);

    // Pause at Q=2 for three cycles delays done by four.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'd5);
    runCycles(2, 1'b0, 1'b0, 4'd0);
    runCycles(3, 1'b1, 1'b0, 4'd0);
    checkOutput("pause_st", 32'(state), 32'(ST_HOLD));
    checkOutput("pause_q", 32'(Q), 32'd2);
    runCycles(1, 1'b0, 1'b0, 4'd0);
    checkOutput("resume_st", 32'(state), 32'(ST_RUN));
    checkOutput("resume_q", 32'(Q), 32'd2);
    runCycles(3, 1'b0, 1'b0, 4'd0);
    checkOutput("pause_no_done", 32'(done), 32'd0);
    runCycles(1, 1'b0, 1'b0, 4'd0);
    checkOutput("pause_done", 32'(done), 32'd1);

    // Stop from DONE, pause in IDLE, then start+stop together mid-RUN.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
    checkOutput("idle_pause", 32'(state), 32'(ST_IDLE));
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'd9);
    runCycles(4, 1'b0, 1'b0, 4'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 4'd9);
    checkOutput("prio_st", 32'(state), 32'(ST_IDLE));
    checkOutput("prio_q", 32'(Q), 32'd0);
    checkOutput("prio_done", 32'(done), 32'd0);

    // Start during RUN is ignored.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'd9);
    runCycles(2, 1'b0, 1'b0, 4'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'd1);
    checkOutput("run_start_q", 32'(Q), 32'd3);

    // Asynchronous reset mid-RUN at Q=3.
    rst = 1'b1;
    #2;
    checkOutput("arst_q", 32'(Q), 32'd0);
    checkOutput("arst_state", 32'(state), 32'(ST_IDLE));
    checkOutput("arst_busy", 32'(busy), 32'd0);
    checkOutput("arst_done", 32'(done), 32'd0);
    checkOutput("arst_periods", 32'(periods), 32'd0);
    modelReset();
    #3;
    rst = 1'b0;

    // term=0 one-shot.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    checkOutput("t0os_st", 32'(state), 32'(ST_DONE));
    checkOutput("t0os_done", 32'(done), 32'd1);
    checkOutput("t0os_periods", 32'(periods), 32'd1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);

    // term=0 periodic: done every cycle, periods wraps past 255.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 4'd0);
    runCycles(260, 1'b0, 1'b0, 4'd0);
    checkOutput("t0per_done", 32'(done), 32'd1);
    checkOutput("t0per_st", 32'(state), 32'(ST_RUN));
    checkOutput("t0per_wrap", 32'(periods), 32'd4);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);

    // term=15 periodic wraps through the terminal rule.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 4'd15);
    runCycles(14, 1'b0, 1'b0, 4'd0);
    checkOutput("t15_q14", 32'(Q), 32'd14);
    runCycles(1, 1'b0, 1'b0, 4'd0);
    checkOutput("t15_q15", 32'(Q), 32'd15);
    checkOutput("t15_nodone", 32'(done), 32'd0);
    runCycles(1, 1'b0, 1'b0, 4'd0);
    checkOutput("t15_q0", 32'(Q), 32'd0);
    checkOutput("t15_done", 32'(done), 32'd1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);

    // Restart from DONE with term=2.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'd1);
    runCycles(2, 1'b0, 1'b0, 4'd0);
    checkOutput("pre_restart", 32'(state), 32'(ST_DONE));
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'd2);
    checkOutput("restart_periods0", 32'(periods), 32'd0);
    runCycles(2, 1'b0, 1'b0, 4'd0);
    checkOutput("restart_nodone", 32'(done), 32'd0);
    runCycles(1, 1'b0, 1'b0, 4'd0);
    checkOutput("restart_done", 32'(done), 32'd1);
    checkOutput("restart_periods", 32'(periods), 32'd1);

    // Random command mix against the model.
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0,
                    $urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)),
                    SIZE'($urandom_range(0, 15)));
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
